stage_fetch: RTL and testbench

- Instruction-fetch stage of the in-order RISC-V pipeline, directly upstream of the decode stage.
- Holds the architectural PC and issues single-outstanding requests to the instruction memory/cache.
- Buffers returned instructions in a 2-entry queue so decode stalls do not lose fetched words.
- Redirects on taken branch/jump and presents registered {pc, instr, valid} to decode.

---
 rtl/stage_fetch_pkg.sv | 22 ++
 rtl/stage_fetch_queue.sv | 73 +++++++
 rtl/stage_fetch.sv | 148 ++++++++++++++
 tb/tb_stage_fetch.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/stage_fetch_pkg.sv
// Shared constants, state encoding and helpers for the instruction-fetch stage.
package stage_fetch_pkg;

    localparam int INSTR_SIZE = 32;

    // addi x0, x0, 0: presented to decode whenever no real instruction is available
    localparam logic [INSTR_SIZE-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [INSTR_SIZE-1:0] RESET_PC_DEFAULT = 32'h0000_1000;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_t;

    // Force an address onto a word boundary.
    function automatic logic [INSTR_SIZE-1:0] align_word(input logic [INSTR_SIZE-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/stage_fetch_queue.sv
// Small FIFO of {pc, instr} pairs between the memory response and the decode
// output register. Flush empties it in one cycle; DEPTH must be a power of two
// so the pointers wrap for free.
module stage_fetch_queue
    import stage_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           push,
    input  logic [INSTR_SIZE-1:0]          push_pc,
    input  logic [INSTR_SIZE-1:0]          push_instr,
    input  logic                           pop,
    output logic [INSTR_SIZE-1:0]          head_pc,
    output logic [INSTR_SIZE-1:0]          head_instr,
    output logic [$clog2(DEPTH):0]         count,
    output logic                           empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [INSTR_SIZE-1:0] pc_mem_r    [DEPTH];
    logic [INSTR_SIZE-1:0] instr_mem_r [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  full_s;
    logic                  do_push_s;
    logic                  do_pop_s;

    assign full_s     = (count_r == CNT_W'(DEPTH));
    assign empty      = (count_r == {CNT_W{1'b0}});
    assign count      = count_r;
    assign head_pc    = pc_mem_r[rd_ptr_r];
    assign head_instr = instr_mem_r[rd_ptr_r];
    assign do_push_s  = push && !full_s;
    assign do_pop_s   = pop && !empty;

    // Storage, pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]    <= {INSTR_SIZE{1'b0}};
                instr_mem_r[i] <= NOP_INSTR;
            end
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                pc_mem_r[wr_ptr_r]    <= push_pc;
                instr_mem_r[wr_ptr_r] <= push_instr;
                wr_ptr_r              <= wr_ptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/stage_fetch.sv
// Instruction-fetch stage: owns the architectural PC, keeps a single request
// outstanding to instruction memory, buffers responses and feeds decode through
// a registered {pc, instr, valid} interface. A taken branch/jump overrides all.
module stage_fetch
    import stage_fetch_pkg::*;
#(
    parameter logic [INSTR_SIZE-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int                    FQ_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [INSTR_SIZE-1:0] redirect_pc_i,
    output logic                  imem_req_o,
    output logic [INSTR_SIZE-1:0] imem_addr_o,
    input  logic                  imem_rvalid_i,
    input  logic [INSTR_SIZE-1:0] imem_rdata_i,
    output logic [INSTR_SIZE-1:0] pc_o,
    output logic [INSTR_SIZE-1:0] instr_o,
    output logic                  instr_valid_o
);

    localparam int               CNT_W   = $clog2(FQ_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FQ_DEPTH);

    fetch_state_t          state_r;
    fetch_state_t          state_nxt_s;
    logic [INSTR_SIZE-1:0] pc_r;
    logic [INSTR_SIZE-1:0] pc_nxt_s;

    logic [INSTR_SIZE-1:0] q_head_pc_s;
    logic [INSTR_SIZE-1:0] q_head_instr_s;
    logic [CNT_W-1:0]      q_count_s;
    logic                  q_empty_s;

    logic                  can_issue_s;
    logic                  req_s;
    logic                  push_s;
    logic                  pop_s;

    // A request is only issued when the queue can absorb its response, so the
    // in-flight word always has a slot even if decode stalls meanwhile.
    assign can_issue_s = (q_count_s < DEPTH_C);
    assign req_s       = (state_r == S_REQ) && can_issue_s && !redirect_i && !reset;
    assign push_s      = (state_r == S_WAIT) && imem_rvalid_i && !redirect_i;
    assign pop_s       = !redirect_i && !stall_i && !q_empty_s;

    assign imem_req_o  = req_s;
    assign imem_addr_o = req_s ? pc_r : {INSTR_SIZE{1'b0}};

    stage_fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_i),
        .push       (push_s),
        .push_pc    (pc_r),
        .push_instr (imem_rdata_i),
        .pop        (pop_s),
        .head_pc    (q_head_pc_s),
        .head_instr (q_head_instr_s),
        .count      (q_count_s),
        .empty      (q_empty_s)
    );

    // Next FSM state; a response that lands in the redirect cycle retires the
    // outstanding request, so the FSM goes straight back to issuing.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_REQ: begin
                if (redirect_i) begin
                    state_nxt_s = S_REQ;
                end else if (can_issue_s) begin
                    state_nxt_s = S_WAIT;
                end else begin
                    state_nxt_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    state_nxt_s = S_REQ;
                end else if (redirect_i) begin
                    state_nxt_s = S_DRAIN;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid_i) begin
                    state_nxt_s = S_REQ;
                end else begin
                    state_nxt_s = S_DRAIN;
                end
            end
            default: state_nxt_s = S_REQ;
        endcase
    end

    // Next PC: redirect target wins, otherwise advance one word per accepted response.
    always_comb begin
        pc_nxt_s = pc_r;
        if (redirect_i) begin
            pc_nxt_s = align_word(redirect_pc_i);
        end else if (push_s) begin
            pc_nxt_s = pc_r + 32'd4;
        end else begin
            pc_nxt_s = pc_r;
        end
    end

    // FSM state and architectural PC registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_REQ;
            pc_r    <= RESET_PC;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
        end
    end

    // Decode-facing output register: redirect squashes, stall holds, otherwise pop or bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_o          <= RESET_PC;
            instr_o       <= NOP_INSTR;
            instr_valid_o <= 1'b0;
        end else if (redirect_i) begin
            instr_o       <= NOP_INSTR;
            instr_valid_o <= 1'b0;
        end else if (stall_i) begin
            pc_o          <= pc_o;
            instr_o       <= instr_o;
            instr_valid_o <= instr_valid_o;
        end else if (!q_empty_s) begin
            pc_o          <= q_head_pc_s;
            instr_o       <= q_head_instr_s;
            instr_valid_o <= 1'b1;
        end else begin
            instr_o       <= NOP_INSTR;
            instr_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stage_fetch.sv
// Bench for stage_fetch: a directed cycle table followed by a randomized run
// against a program-order reference model.
module tb_stage_fetch;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] RPC   = 32'h0000_1000;
    localparam int          DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic        instr_valid_o;

    int n_checks = 0;
    int n_fail   = 0;

    stage_fetch #(.RESET_PC(RPC), .FQ_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .pc_o          (pc_o),
        .instr_o       (instr_o),
        .instr_valid_o (instr_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        rv;
        logic [31:0] rdata;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic [31:0] epc;
        logic [31:0] einstr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic stall, input logic redir,
                                input logic [31:0] rpc, input logic rv, input logic [31:0] rdata,
                                input logic ereq, input logic [31:0] eaddr, input logic evalid,
                                input logic [31:0] epc, input logic [31:0] einstr);
        vec_t v;
        v.rst = rst; v.stall = stall; v.redir = redir; v.rpc = rpc; v.rv = rv; v.rdata = rdata;
        v.ereq = ereq; v.eaddr = eaddr; v.evalid = evalid; v.epc = epc; v.einstr = einstr;
        return v;
    endfunction

    function automatic logic [31:0] dw(input int k);
        return 32'hD000_0000 + 32'(k);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    // random-phase model state
    logic [31:0] mq_pc[$];
    logic [31:0] mq_in[$];
    logic        m_valid;
    logic [31:0] m_pc, m_instr, m_fetch_pc, out_addr;
    logic        outst, got_resp, exp_req;
    int          lat, epoch, resp_epoch, accepted;

    initial begin
        reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;

        //            rst   stl   red   rpc            rv    rdata          req   addr           val   pc             instr
        vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,RPC,          NOP));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h1000,     1'b0,RPC,          NOP));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b1,dw(0),        1'b0,32'h0,        1'b0,RPC,          NOP));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h1004,     1'b0,RPC,          NOP));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b1,dw(1),        1'b0,32'h0,        1'b1,32'h1000,     dw(0)));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h1008,     1'b0,32'h1000,     NOP));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b1,dw(2),        1'b0,32'h0,        1'b1,32'h1004,     dw(1)));
        // stall: queue fills, requests stop
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h100C,     1'b0,32'h1004,     NOP));
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h0,        1'b1,dw(3),        1'b0,32'h0,        1'b0,32'h1004,     NOP));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1'b0,1'b1,1'b0,32'h0,    1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h1004,     NOP));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h1004,     NOP));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h1010,     1'b1,32'h1008,     dw(2)));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h100C,     dw(3)));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b1,dw(4),        1'b0,32'h0,        1'b0,32'h100C,     NOP));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h1014,     1'b0,32'h100C,     NOP));
        // redirect in S_WAIT, stale response 3 cycles later
        vecs.push_back(mk(1'b0,1'b0,1'b1,32'h2002,     1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h1010,     dw(4)));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h1010,     NOP));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h1010,     NOP));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b1,32'hBAD0_0001,1'b0,32'h0,        1'b0,32'h1010,     NOP));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h2000,     1'b0,32'h1010,     NOP));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b1,dw(5),        1'b0,32'h0,        1'b0,32'h1010,     NOP));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h2004,     1'b0,32'h1010,     NOP));
        // redirect coincident with rvalid and stall
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h2000,     dw(5)));
        vecs.push_back(mk(1'b0,1'b1,1'b1,32'h3000,     1'b1,32'hBAD0_0002,1'b0,32'h0,        1'b1,32'h2000,     dw(5)));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h3000,     1'b0,32'h2000,     NOP));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b1,dw(7),        1'b0,32'h0,        1'b0,32'h2000,     NOP));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h3004,     1'b0,32'h2000,     NOP));
        // redirect to the top word, then wrap to zero
        vecs.push_back(mk(1'b0,1'b0,1'b1,32'hFFFF_FFFF,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h3000,     dw(7)));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b1,32'hBAD0_0003,1'b0,32'h0,        1'b0,32'h3000,     NOP));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'hFFFF_FFFC,1'b0,32'h3000,     NOP));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b1,dw(8),        1'b0,32'h0,        1'b0,32'h3000,     NOP));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h0,        1'b0,32'h3000,     NOP));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1,32'hFFFF_FFFC,dw(8)));
        // reset in S_WAIT with one entry queued
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h0,        1'b1,dw(9),        1'b0,32'h0,        1'b0,32'hFFFF_FFFC,NOP));
        vecs.push_back(mk(1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h4,        1'b0,32'hFFFF_FFFC,NOP));
        vecs.push_back(mk(1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,32'hFFFF_FFFC,NOP));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h1000,     1'b0,RPC,          NOP));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b1,dw(10),       1'b0,32'h0,        1'b0,RPC,          NOP));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h1004,     1'b0,RPC,          NOP));
        vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1,RPC,          dw(10)));

        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            reset         = vecs[i].rst;
            stall_i       = vecs[i].stall;
            redirect_i    = vecs[i].redir;
            redirect_pc_i = vecs[i].rpc;
            imem_rvalid_i = vecs[i].rv;
            imem_rdata_i  = vecs[i].rdata;
            @(negedge clk);
            chk("tbl_req",   i, {31'h0, imem_req_o},    {31'h0, vecs[i].ereq});
            chk("tbl_addr",  i, imem_addr_o,            vecs[i].eaddr);
            chk("tbl_valid", i, {31'h0, instr_valid_o}, {31'h0, vecs[i].evalid});
            chk("tbl_pc",    i, pc_o,                   vecs[i].epc);
            chk("tbl_instr", i, instr_o,                vecs[i].einstr);
        end

        // randomized run against the program-order model
        @(posedge clk); #1;
        reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; imem_rvalid_i = 1'b0;
        repeat (2) @(posedge clk);
        mq_pc.delete(); mq_in.delete();
        m_valid = 1'b0; m_pc = RPC; m_instr = NOP; m_fetch_pc = RPC;
        outst = 1'b0; lat = 0; epoch = 0; resp_epoch = 0; accepted = 0; out_addr = 32'h0;

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            reset         = 1'b0;
            stall_i       = ($urandom_range(0, 99) < 30);
            redirect_i    = ($urandom_range(0, 99) < 4);
            redirect_pc_i = $urandom;
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
            if (outst) begin
                lat = lat - 1;
                if (lat == 0) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = mem_word(out_addr);
                end
            end
            @(negedge clk);
            exp_req = !outst && !redirect_i && (mq_pc.size() < DEPTH);
            chk("rnd_req", c, {31'h0, imem_req_o}, {31'h0, exp_req});
            if (imem_req_o) chk("rnd_addr", c, imem_addr_o, m_fetch_pc);
            chk("rnd_valid", c, {31'h0, instr_valid_o}, {31'h0, m_valid});
            chk("rnd_pc",    c, pc_o,    m_pc);
            chk("rnd_instr", c, instr_o, m_instr);

            got_resp = imem_rvalid_i;
            if (redirect_i) begin
                mq_pc.delete(); mq_in.delete();
                m_valid    = 1'b0;
                m_instr    = NOP;
                m_fetch_pc = redirect_pc_i & 32'hFFFF_FFFC;
                epoch++;
            end else begin
                if (!stall_i) begin
                    if (mq_pc.size() > 0) begin
                        m_pc    = mq_pc.pop_front();
                        m_instr = mq_in.pop_front();
                        m_valid = 1'b1;
                    end else begin
                        m_instr = NOP;
                        m_valid = 1'b0;
                    end
                end
                if (got_resp && resp_epoch == epoch) begin
                    mq_pc.push_back(out_addr);
                    mq_in.push_back(imem_rdata_i);
                    m_fetch_pc = out_addr + 32'd4;
                    accepted++;
                end
            end
            if (got_resp) outst = 1'b0;
            if (imem_req_o) begin
                outst      = 1'b1;
                out_addr   = imem_addr_o;
                resp_epoch = epoch;
                lat        = $urandom_range(1, 4);
            end
        end
        chk("rnd_progress", 0, {31'h0, (accepted > 100)}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
